// File: rtl/yapp_router_n.sv
// yapp_router_n -- YAPP packet router, one input stream to NUM_CH byte FIFOs.
//
// A packet is a header byte {length, addr}, `length` payload bytes and one
// parity byte (XOR of header and payload). Good packets are copied verbatim
// into the FIFO of channel `addr`. Packets with a bad address, excessive
// length, or arriving while the router is disabled are consumed and dropped.
// A parity mismatch still forwards the packet but pulses `error`.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_data/in_data_vld     input byte stream; in_suspend stalls it
//   error                   one-cycle parity-error pulse
//   data/data_vld/suspend   per-channel output bytes with back-pressure
//   haddr/hdata_w/hdata_r/hen/hwr_rd  host register bus (hwr_rd=1 write)
//
// Host map: 0x00 max_pkt_size (RW), 0x01 router_en (RW bit0),
//           0x02 parity_err_cnt (RO, saturating),
//           0x03 drop_cnt (RO, saturating), 0x04 forwarded count (RO, wrapping)
// Macro YAPP_ROUTER_STATS_EN: when defined, 0x03/0x04 are backed by counters;
// otherwise they read 0.

// Per-channel FIFO; output reads 0 while empty.
module yapp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push_ok, pop_ok;

  // full/empty come straight from the registered count.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

module yapp_router_n #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_vld,
  output logic                     in_suspend,
  output logic                     error,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        data_vld,
  input  logic [NUM_CH-1:0]        suspend,
  input  logic [7:0]               haddr,
  input  logic [7:0]               hdata_w,
  output logic [7:0]               hdata_r,
  input  logic                     hen,
  input  logic                     hwr_rd
);
  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int NCH_P2 = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PARITY, DROP} state_t;

  typedef struct packed {
    logic       en;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } host_req_t;

  state_t            state, nstate;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] par_q;     // running parity; equals the header while in HDR
  logic [7:0]        max_pkt_size, par_err_cnt, rd_mux;
  logic              router_en, err_q;
  logic              acc, hdr_drop, cur_full, push_en;
  logic [DATA_W-1:0] push_din;
  logic [NUM_CH-1:0] full, empty, push;
  logic [NCH_P2-1:0] full_x;
  host_req_t         hreq;
  logic              unused_ok;

  assign hreq      = '{en: hen, wr: hwr_rd, addr: haddr, wdata: hdata_w};
  assign unused_ok = ^hdata_w[7:1];

  // Pad the full vector to a power of two so any addr_q indexes safely.
  always_comb begin
    full_x = '0;
    full_x[NUM_CH-1:0] = full;
  end
  assign cur_full = full_x[addr_q];

  assign in_suspend = (state == HDR) |
                      (((state == PAYLOAD) | (state == PARITY)) & cur_full);
  assign acc   = in_data_vld & ~in_suspend;
  assign error = err_q;

  assign hdr_drop = (32'(in_data[ADDR_W-1:0]) >= NUM_CH) |
                    (32'(in_data[DATA_W-1:ADDR_W]) > 32'(max_pkt_size)) |
                    ~router_en;

  always_comb begin
    nstate   = state;
    push_en  = 1'b0;
    push_din = in_data;
    case (state)
      IDLE:    if (acc) nstate = hdr_drop ? DROP : HDR;
      HDR:     if (!cur_full) begin
                 push_en  = 1'b1;
                 push_din = par_q;
                 nstate   = (len_q == '0) ? PARITY : PAYLOAD;
               end
      PAYLOAD: if (acc) begin
                 push_en = 1'b1;
                 if (len_q == LEN_W'(1)) nstate = PARITY;
               end
      PARITY:  if (acc) begin
                 push_en = 1'b1;
                 nstate  = IDLE;
               end
      DROP:    if (acc && len_q == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Packet datapath; DROP reuses len_q so length+1 bytes are consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      par_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state == PARITY) & acc & (in_data != par_q);
      if (acc) begin
        case (state)
          IDLE: begin
            addr_q <= in_data[ADDR_W-1:0];
            len_q  <= in_data[DATA_W-1:ADDR_W];
            par_q  <= in_data;
          end
          PAYLOAD: begin
            par_q <= par_q ^ in_data;
            len_q <= len_q - LEN_W'(1);
          end
          DROP:    len_q <= len_q - LEN_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Channel FIFOs
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign push[gi] = push_en & (addr_q == ADDR_W'(gi));
      yapp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push[gi]),
        .din   (push_din),
        .pop   (data_vld[gi] & ~suspend[gi]),
        .dout  (data[gi*DATA_W +: DATA_W]),
        .full  (full[gi]),
        .empty (empty[gi])
      );
      assign data_vld[gi] = ~empty[gi];
    end
  endgenerate

  // Host registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_pkt_size <= 8'h3F;
      router_en    <= 1'b1;
      par_err_cnt  <= '0;
      hdata_r      <= '0;
    end else begin
      if (hreq.en && hreq.wr) begin
        case (hreq.addr)
          8'h00:   max_pkt_size <= hreq.wdata;
          8'h01:   router_en    <= hreq.wdata[0];
          default: ;
        endcase
      end
      if (hreq.en && !hreq.wr) hdata_r <= rd_mux;
      if ((state == PARITY) && acc && (in_data != par_q) && (par_err_cnt != 8'hFF))
        par_err_cnt <= par_err_cnt + 8'd1;
    end
  end

`ifdef YAPP_ROUTER_STATS_EN
  logic [7:0] drop_cnt, fwd_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      fwd_cnt  <= '0;
    end else begin
      if ((state == IDLE) && acc && hdr_drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if ((state == PARITY) && acc)
        fwd_cnt <= fwd_cnt + 8'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (hreq.addr)
      8'h00:   rd_mux = max_pkt_size;
      8'h01:   rd_mux = {7'd0, router_en};
      8'h02:   rd_mux = par_err_cnt;
      8'h03:   rd_mux = drop_cnt;
      8'h04:   rd_mux = fwd_cnt;
      default: rd_mux = '0;
    endcase
  end
`else
  always_comb begin
    rd_mux = '0;
    case (hreq.addr)
      8'h00:   rd_mux = max_pkt_size;
      8'h01:   rd_mux = {7'd0, router_en};
      8'h02:   rd_mux = par_err_cnt;
      default: rd_mux = '0;
    endcase
  end
`endif
endmodule
